// File: rtl/dmem_sram_like_bridge.sv
// rtl/dmem_sram_like_bridge.sv - core data-memory port to sram-like split-handshake bus bridge
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   cpu_en, cpu_wen,         core access request: enable, byte write enables,
//   cpu_size, cpu_addr,      size (0 byte, 1 half, 2 word), byte address,
//   cpu_wdata                store data
//   ext_stall                stall from other pipeline sources
//   cpu_rdata, cpu_stall     load data and pipeline hold back to the core
//   req, wr, size, addr,     sram-like request channel (addr is translated)
//   wdata
//   addr_ok, data_ok, rdata  slave accept / data-phase complete / read data

module dmem_sram_like_bridge #(
    parameter logic KSEG_MAP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic [3:0]  cpu_wen,
    input  logic [1:0]  cpu_size,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        ext_stall,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        req,
    output logic        wr,
    output logic [1:0]  size,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic        addr_ok,
    input  logic        data_ok,
    input  logic [31:0] rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [31:0] addr_xlat;
    logic        capture_en;
    logic        rdata_en;

    // kseg0 (0x8000_0000..) and kseg1 (0xA000_0000..) both alias physical low memory.
    always_comb begin
        addr_xlat = cpu_addr;
        if (KSEG_MAP == 1'b1) begin
            case (cpu_addr[31:29])
                3'b100,
                3'b101:  addr_xlat = {3'b000, cpu_addr[28:0]};
                default: addr_xlat = cpu_addr;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        cpu_stall = 1'b0;
        req       = 1'b0;
        case (state_q)
            IDLE: begin
                cpu_stall = cpu_en;
                if (cpu_en) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                req       = 1'b1;
                cpu_stall = 1'b1;
                // data_ok without addr_ok cannot belong to this request; ignore it.
                if (addr_ok) begin
                    state_d = data_ok ? DONE : WAIT;
                end
            end
            WAIT: begin
                cpu_stall = 1'b1;
                if (data_ok) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // The instruction that issued this access is still presented
                // while ext_stall holds the pipeline, so no new capture here.
                if (!ext_stall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign capture_en = (state_q == IDLE) && cpu_en;
    assign rdata_en   = !wr && (((state_q == REQ) && addr_ok && data_ok) ||
                                ((state_q == WAIT) && data_ok));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wr        <= 1'b0;
            size      <= 2'd0;
            addr      <= 32'd0;
            wdata     <= 32'd0;
            cpu_rdata <= 32'd0;
        end else begin
            state_q <= state_d;
            if (capture_en) begin
                wr    <= |cpu_wen;
                size  <= cpu_size;
                addr  <= addr_xlat;
                wdata <= cpu_wdata;
            end
            if (rdata_en) begin
                cpu_rdata <= rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_sram_like_bridge.sv
// tb/tb_dmem_sram_like_bridge.sv - self-checking bench for dmem_sram_like_bridge

module tb_dmem_sram_like_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        ext_stall;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    dmem_sram_like_bridge #(.KSEG_MAP(1'b1)) dut (
        .clk(clk), .rst(rst),
        .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_size(cpu_size),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .ext_stall(ext_stall),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding access, tracked as
    // busy (issued, not complete), accepted (slave took the address),
    // finished (result being presented to the core).
    logic        m_busy = 0, m_acc = 0, m_fin = 0;
    logic        m_wr = 0;
    logic [1:0]  m_size = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;

    function automatic logic [31:0] phys(input logic [31:0] va);
        if (va >= 32'h8000_0000 && va < 32'hC000_0000) return va - 32'h8000_0000
            + ((va >= 32'hA000_0000) ? -32'sd536870912 : 32'sd0);
        return va;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_acc = 0; m_fin = 0;
            m_wr = 0; m_size = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
        end else if (m_fin) begin
            if (!ext_stall) m_fin = 0;
        end else if (m_busy) begin
            if (data_ok && (m_acc || addr_ok)) begin
                m_busy = 0; m_acc = 0; m_fin = 1;
                if (!m_wr) m_rdata = rdata;
            end else if (addr_ok) begin
                m_acc = 1;
            end
        end else if (cpu_en) begin
            m_busy  = 1;
            m_wr    = (cpu_wen != 4'd0);
            m_size  = cpu_size;
            m_addr  = phys(cpu_addr);
            m_wdata = cpu_wdata;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req",       {31'd0, req},       {31'd0, m_busy && !m_acc});
            chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, m_fin ? 1'b0 : (m_busy ? 1'b1 : cpu_en)});
            chk("wr",        {31'd0, wr},        {31'd0, m_wr});
            chk("size",      {30'd0, size},      {30'd0, m_size});
            chk("addr",      addr,               m_addr);
            chk("wdata",     wdata,              m_wdata);
            chk("cpu_rdata", cpu_rdata,          m_rdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_en = 0; cpu_wen = 0; cpu_size = 0; cpu_addr = 32'h0;
        cpu_wdata = 32'h0; ext_stall = 0; addr_ok = 0; data_ok = 0; rdata = 32'h0;
    endtask

    // One core access: addr_ok aok cycles after req rises, data_ok dok cycles
    // after addr_ok, DONE held by ext_stall for hold cycles.
    task automatic access(input string tag, input logic [3:0] wen, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int aok, input int dok, input logic [31:0] rd,
                          input int hold, input int exp_stall_n, input int exp_req_n);
        int stall_n = 0;
        int req_n   = 0;
        cpu_en = 1; cpu_wen = wen; cpu_size = sz; cpu_addr = a; cpu_wdata = wd;
        for (int c = 0; c <= 2 + aok + dok + hold; c++) begin
            addr_ok   = (c == 1 + aok);
            data_ok   = (c == 1 + aok + dok);
            rdata     = data_ok ? rd : (32'h0BAD_0000 + c);
            ext_stall = (c >= 2 + aok + dok) && (c < 2 + aok + dok + hold);
            @(negedge clk);
            if (cpu_stall) stall_n++;
            if (req) req_n++;
            step();
        end
        chk({tag, "_stall_cycles"}, stall_n, exp_stall_n);
        chk({tag, "_req_cycles"},   req_n,   exp_req_n);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        step();
        step();
        chk_en = 1;
        chk("reset_req",   {31'd0, req},       32'd0);
        chk("reset_addr",  addr,               32'd0);
        chk("reset_rdata", cpu_rdata,          32'd0);
        rst = 0;

        // Idle with stray handshakes: nothing may happen.
        addr_ok = 1; data_ok = 1; rdata = 32'h5555_AAAA;
        step();
        step();
        idle_inputs();

        access("load_slow", 4'b0000, 2'd2, 32'h8000_0010, 32'h0, 2, 3, 32'hDEAD_BEEF, 0, 7, 3);
        chk("load_slow_addr",  addr,      32'h0000_0010);
        chk("load_slow_rdata", cpu_rdata, 32'hDEAD_BEEF);
        step();

        access("store_fast", 4'b1111, 2'd2, 32'h9FC0_0000, 32'h1234_5678, 0, 0, 32'h7777_7777, 0, 2, 1);
        chk("store_fast_addr",  addr,             32'h1FC0_0000);
        chk("store_fast_wdata", wdata,            32'h1234_5678);
        chk("store_fast_wr",    {31'd0, wr},      32'd1);
        chk("store_keep_rdata", cpu_rdata,        32'hDEAD_BEEF);
        step();

        access("byte_store", 4'b0010, 2'd0, 32'h0000_0101, 32'hAB00_CD00, 1, 1, 32'h0, 0, 4, 2);
        chk("byte_store_addr", addr,         32'h0000_0101);
        chk("byte_store_size", {30'd0, size}, 32'd0);

        access("hold", 4'b0000, 2'd2, 32'hBFAF_F000, 32'h0, 0, 2, 32'hCAFE_F00D, 4, 4, 1);
        chk("hold_addr",  addr,      32'h1FAF_F000);
        chk("hold_rdata", cpu_rdata, 32'hCAFE_F00D);

        access("b2b_a", 4'b0000, 2'd2, 32'hA000_0004, 32'h0, 1, 0, 32'h1111_2222, 0, 3, 2);
        access("b2b_b", 4'b0000, 2'd1, 32'h0000_1000, 32'h0, 0, 1, 32'h3333_4444, 0, 3, 1);
        chk("b2b_addr",  addr,      32'h0000_1000);
        chk("b2b_rdata", cpu_rdata, 32'h3333_4444);

        // Reset while waiting for the data phase; the late data_ok is dropped.
        cpu_en = 1; cpu_addr = 32'h8000_0040;
        step();                 // IDLE detect
        addr_ok = 1;
        step();                 // REQ accepted
        addr_ok = 0;
        step();                 // WAIT
        rst = 1; cpu_en = 0;
        step();
        rst = 0; data_ok = 1; rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("rst_req",   {31'd0, req},       32'd0);
        chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
        step();
        idle_inputs();
        @(negedge clk);
        chk("rst_rdata", cpu_rdata, 32'd0);
        step();

        access("post_rst", 4'b0000, 2'd2, 32'h0000_2000, 32'h0, 0, 0, 32'h0F0F_0F0F, 0, 2, 1);
        chk("post_rst_rdata", cpu_rdata, 32'h0F0F_0F0F);
        step();

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_sram_like_bridge.md
Name: dmem_sram_like_bridge

Overview:
- Downstream of the mips core's data-memory port: consumes Mem_en / Mem_write_en / Mem_addr / Write_data and returns read data plus a stall.
- Converts the core's single-cycle memory interface into a split-handshake sram-like bus (req/addr_ok/data_ok) feeding the AXI bridge/cache.
- Holds the core in stall while exactly one transaction is outstanding.
- Performs fixed kseg0/kseg1 address translation.

Parameters:
- KSEG_MAP, 1, when 1, addresses with addr[31:29] equal to 3'b100 or 3'b101 are issued as {3'b000, addr[28:0]}; when 0, addresses pass unchanged.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_en  in  1  core memory access enable (Mem_en).
- cpu_wen  in  4  byte write enables (Mem_write_en); nonzero means a store.
- cpu_size  in  2  access size: 0 = byte, 1 = half, 2 = word.
- cpu_addr  in  32  byte address (Mem_addr).
- cpu_wdata  in  32  store data (Write_data).
- ext_stall  in  1  stall from other pipeline sources; the core does not advance while high.
- cpu_rdata  out  32  load data returned to the core.
- cpu_stall  out  1  the core must hold all pipeline registers.
- req  out  1  bus request valid.
- wr  out  1  1 = write.
- size  out  2  registered copy of cpu_size.
- addr  out  32  translated address.
- wdata  out  32  registered copy of cpu_wdata.
- addr_ok  in  1  slave accepted the request this cycle.
- data_ok  in  1  slave completed the data phase this cycle.
- rdata  in  32  read data; valid when data_ok = 1.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state = IDLE, req = 0, wr = 0, size = 0, addr = 0, wdata = 0, cpu_rdata = 0.
- IDLE:
  - cpu_stall = cpu_en (combinational).
  - If cpu_en = 1: capture wr = |cpu_wen, size, translated addr and wdata, then go to REQ.
  - data_ok and addr_ok are ignored in IDLE.
- REQ:
  - req = 1, cpu_stall = 1. Bus fields stay stable until addr_ok.
  - addr_ok & data_ok → DONE; capture rdata when wr = 0.
  - addr_ok only → WAIT.
  - Otherwise stay in REQ.
- WAIT:
  - req = 0, cpu_stall = 1.
  - data_ok → DONE; capture rdata into cpu_rdata when wr = 0.
- DONE:
  - cpu_stall = 0, so the core sees cpu_rdata this cycle.
  - ext_stall = 1 → stay in DONE. The result is held and no new request is issued for the still-present old instruction.
  - ext_stall = 0 → IDLE.
  - Core inputs seen in DONE always belong to the completed access and never start a new transaction.
- Latency:
  - Minimum load/store occupancy is 3 cycles (IDLE detect, REQ with addr_ok & data_ok, DONE).
  - cpu_stall is high from the first cycle cpu_en is seen until DONE.
- Stores: cpu_rdata is not updated. Stores use the same handshake; completion is data_ok.
- Outstanding transactions: at most one. req is never asserted in WAIT or DONE.
- Address mapping: translation is applied at capture. 0x9FC0_0000 → 0x1FC0_0000, 0xBFAF_F000 → 0x1FAF_F000; 0x0000_1000 is unchanged. KSEG_MAP = 0 disables all translation.
- Reset mid-operation: rst in REQ or WAIT returns to IDLE next edge and drops req. A late data_ok arriving in IDLE is ignored, and cpu_rdata stays 0.
- cpu_en = 0 in IDLE: no bus activity and cpu_stall = 0.

Test Plan:
- Load, delayed bus: cpu_en = 1, wen = 0, addr 0x8000_0010; addr_ok 2 cycles after req, data_ok 3 cycles later with rdata 0xDEADBEEF → addr = 0x0000_0010, wr = 0; cpu_stall high until DONE; DONE shows cpu_rdata = 0xDEADBEEF with stall = 0 for exactly 1 cycle.
- Store, fast slave: wen = 4'b1111, size = 2, wdata 0x12345678; addr_ok & data_ok in the first REQ cycle → wr = 1, wdata = 0x12345678, req high for 1 cycle, total 3 cycles, cpu_rdata unchanged.
- Byte store: wen = 4'b0010, size = 0, addr 0x0000_0101 → wr = 1, size = 0, addr = 0x0000_0101.
- ext_stall hold: ext_stall = 1 for 4 cycles on reaching DONE → state stays DONE, cpu_stall = 0, req = 0, cpu_rdata stable; returns to IDLE the cycle after ext_stall falls.
- Reset mid-transaction: rst pulsed in WAIT, then data_ok with rdata 0xFFFFFFFF → req = 0, cpu_rdata = 0, cpu_stall = 0 with cpu_en = 0.
- Back-to-back loads: two loads on consecutive core instructions → second req rises one cycle after the first DONE; no duplicate request for the first address.
